// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Stall/flush controller for the five-stage openMIPS pipeline. It combines
// the ID/EX/MEM stall requests into a per-stage hold vector and turns an
// exception into a single-cycle flush with a redirect PC. It also counts
// stalled cycles. An optional watchdog forces a flush after a long unbroken
// stall.
//
// Optional feature macro: PIPE_CTRL_WDOG_EN enables the stall watchdog.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stallreq_id     ID hold request (load-use hazard)
//   stallreq_ex     EX hold request (multi-cycle mult/div)
//   stallreq_mem    MEM hold request (memory wait)
//   excp_req        exception pulse from MEM
//   excp_handler    handler address, valid with excp_req
//   stall[5:0]      hold vector: pc, if_id, id_ex, ex_mem, mem_wb, wb
//   flush           clear all pipeline registers
//   new_pc          redirect target, valid while flush=1
//   stall_cnt       number of cycles with stall != 0 (wraps)
//   wdog_timeout    pulse marking a watchdog-caused flush
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned WDOG_LIMIT  = 256,
  parameter logic [31:0] WDOG_VECTOR = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_req,
  input  logic [31:0] excp_handler,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cnt,
  output logic        wdog_timeout
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  w_req_stall;
  logic        w_excp_take;
  logic        w_wdog_fire;
  logic [31:0] r_new_pc;
  logic [31:0] r_stall_cnt;
  logic        r_wdog_to;

  // The deepest requesting stage wins. It holds itself and every stage in
  // front of it.
  always_comb begin
    w_req_stall = 6'b000000;
    if (stallreq_mem)
      w_req_stall = 6'b011111;
    else if (stallreq_ex)
      w_req_stall = 6'b001111;
    else if (stallreq_id)
      w_req_stall = 6'b000111;
  end

  // Requests that arrive while flushing are ignored.
  assign w_excp_take = (r_state == RUN) && excp_req;

`ifdef PIPE_CTRL_WDOG_EN
  logic [31:0] r_wdog_cnt;

  // The watchdog fires on the last stalled RUN cycle before the limit.
  assign w_wdog_fire = (r_state == RUN) && (w_req_stall != 6'b000000) &&
                       (r_wdog_cnt == WDOG_LIMIT - 32'd1);

  // Counts consecutive stalled RUN cycles. It restarts on any unstalled
  // cycle and whenever a flush is taken.
  always_ff @(posedge clk) begin
    if (rst)
      r_wdog_cnt <= 32'd0;
    else if ((r_state == RUN) && (w_req_stall != 6'b000000) && !w_wdog_fire && !w_excp_take)
      r_wdog_cnt <= r_wdog_cnt + 32'd1;
    else
      r_wdog_cnt <= 32'd0;
  end
`else
  logic w_unused_wdog_params;

  assign w_wdog_fire          = 1'b0;
  assign w_unused_wdog_params = ^{WDOG_VECTOR, WDOG_LIMIT};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= RUN;
    else
      r_state <= w_next_state;
  end

  // Next state: FLUSH always lasts exactly one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:     if (w_excp_take || w_wdog_fire) w_next_state = FLUSH;
      FLUSH:   w_next_state = RUN;
      default: w_next_state = RUN;
    endcase
  end

  // Outputs. The hold vector is forced to zero while flushing.
  always_comb begin
    stall = 6'b000000;
    flush = 1'b0;
    case (r_state)
      RUN:     stall = w_req_stall;
      FLUSH:   flush = 1'b1;
      default: stall = 6'b000000;
    endcase
  end

  // The redirect target is captured on the RUN->FLUSH transition. An
  // exception outranks the watchdog. The timeout flag is set only when the
  // watchdog alone caused the flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_new_pc  <= 32'd0;
      r_wdog_to <= 1'b0;
    end else begin
      r_wdog_to <= w_wdog_fire && !w_excp_take;
      if (w_excp_take)
        r_new_pc <= excp_handler;
      else if (w_wdog_fire)
        r_new_pc <= WDOG_VECTOR;
    end
  end

  // Performance counter of stalled cycles. It wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= 32'd0;
    else if (stall != 6'b000000)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign new_pc       = r_new_pc;
  assign stall_cnt    = r_stall_cnt;
  assign wdog_timeout = r_wdog_to;

endmodule
